// File: rtl/seq_stim_gen_pkg.sv
// seq_stim_gen_pkg: shared state type, default parameters and length clamp for seq_stim_gen
package seq_stim_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  localparam int NSIG_DEF = 2;
  localparam int DEPTH_DEF = 8;
  localparam int DLY_W_DEF = 4;
  function automatic int clamp_len(int len, int depth);
    return (len > depth) ? depth : len;
  endfunction
endpackage

// File: rtl/seq_stim_gen_if.sv
// seq_stim_gen_if: pattern-write, run-control and stimulus-output bundle for seq_stim_gen
// master: drives wr_en/wr_idx/wr_sig/wr_dly, start/len/abort; observes sig_o/step_o/busy/done/aborted/wr_drop
// slave : the generator side of the same signals
interface seq_stim_gen_if import seq_stim_gen_pkg::*; #(
  parameter int NSIG  = NSIG_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DLY_W = DLY_W_DEF
) ();
  localparam int IW = $clog2(DEPTH);
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [NSIG-1:0]  wr_sig;
  logic [DLY_W-1:0] wr_dly;
  logic             start;
  logic [IW:0]      len;
  logic             abort;
  logic [NSIG-1:0]  sig_o;
  logic [IW-1:0]    step_o;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             wr_drop;
  modport master (
    output wr_en, wr_idx, wr_sig, wr_dly, start, len, abort,
    input  sig_o, step_o, busy, done, aborted, wr_drop
  );
  modport slave (
    input  wr_en, wr_idx, wr_sig, wr_dly, start, len, abort,
    output sig_o, step_o, busy, done, aborted, wr_drop
  );
endinterface

// File: rtl/seq_stim_gen_mem.sv
// seq_stim_gen_mem: DEPTH x {sig, dly} pattern register file, sync clear, one write port, async read
// clk, rst_n (sync, active-low clear of all entries)
// we_i/waddr_i/wsig_i/wdly_i: write port; raddr_i -> rsig_o/rdly_o: combinational read port
module seq_stim_gen_mem import seq_stim_gen_pkg::*; #(
  parameter int NSIG  = NSIG_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DLY_W = DLY_W_DEF,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [NSIG-1:0]  wsig_i,
  input  logic [DLY_W-1:0] wdly_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [NSIG-1:0]  rsig_o,
  output logic [DLY_W-1:0] rdly_o
);
  logic [NSIG-1:0]  sig_q [DEPTH];
  logic [DLY_W-1:0] dly_q [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sig_q[i] <= '0;
        dly_q[i] <= '0;
      end
    end else if (we_i) begin
      sig_q[waddr_i] <= wsig_i;
      dly_q[waddr_i] <= wdly_i;
    end
  end
  assign rsig_o = sig_q[raddr_i];
  assign rdly_o = dly_q[raddr_i];
endmodule

// File: rtl/seq_stim_gen.sv
// seq_stim_gen: programmable stepped stimulus generator, each step holds a value for dly+1 cycles
// clk, rst_n (sync, active-low); bus (seq_stim_gen_if.slave): pattern writes, start/len/abort,
// sig_o/step_o stimulus, busy level, done/aborted/wr_drop one-cycle pulses
// Optional: define SEQ_STIM_GEN_SVA_EN to compile in concurrent assertions on the run behaviour
module seq_stim_gen import seq_stim_gen_pkg::*; #(
  parameter int              NSIG     = NSIG_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter int              DLY_W    = DLY_W_DEF,
  parameter logic [NSIG-1:0] IDLE_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  seq_stim_gen_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  state_e           state_q;
  logic [NSIG-1:0]  sig_q;
  logic [IW-1:0]    step_q;
  logic [DLY_W-1:0] dly_q;
  logic [LW-1:0]    len_q;
  logic             done_q, aborted_q, drop_q;
  logic [NSIG-1:0]  rd_sig;
  logic [DLY_W-1:0] rd_dly;
  logic [IW-1:0]    rd_idx;
  logic [LW-1:0]    len_c;
  logic             wr_ok, last;
  // The single read port serves step 0 while idle and the following step while running.
  always_comb begin
    len_c  = LW'(clamp_len(int'(bus.len), DEPTH));
    wr_ok  = bus.wr_en && state_q == IDLE && !bus.start;
    rd_idx = (state_q == RUN) ? step_q + IW'(1) : '0;
    last   = LW'(step_q) == len_q - LW'(1);
  end
  seq_stim_gen_mem #(.NSIG(NSIG), .DEPTH(DEPTH), .DLY_W(DLY_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (bus.wr_idx),
    .wsig_i  (bus.wr_sig),
    .wdly_i  (bus.wr_dly),
    .raddr_i (rd_idx),
    .rsig_o  (rd_sig),
    .rdly_o  (rd_dly)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sig_q     <= IDLE_VAL;
      step_q    <= '0;
      dly_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      drop_q    <= bus.wr_en && !wr_ok;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (len_c == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              len_q   <= len_c;
              sig_q   <= rd_sig;
              step_q  <= '0;
              dly_q   <= rd_dly;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            sig_q     <= IDLE_VAL;
            step_q    <= '0;
            dly_q     <= '0;
            aborted_q <= 1'b1;
          end else if (dly_q != '0) begin
            dly_q <= dly_q - DLY_W'(1);
          end else if (!last) begin
            step_q <= step_q + IW'(1);
            sig_q  <= rd_sig;
            dly_q  <= rd_dly;
          end else begin
            state_q <= FIN;
            sig_q   <= IDLE_VAL;
            step_q  <= '0;
            done_q  <= 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.sig_o   = sig_q;
  assign bus.step_o  = step_q;
  assign bus.busy    = state_q == RUN;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.wr_drop = drop_q;
`ifdef SEQ_STIM_GEN_SVA_EN
  logic go;
  assign go = state_q == IDLE && bus.start && !bus.abort && len_c != '0;
  sequence s_stable(input logic [NSIG-1:0] v);
    $stable(v);
  endsequence
  property p_after_done(sequence tail);
    @(posedge clk) disable iff (!rst_n) bus.done |-> tail;
  endproperty
  property p_while_hold(property body);
    @(posedge clk) disable iff (!rst_n) (state_q == RUN && dly_q != '0 && !bus.abort) |=> body;
  endproperty
  // n counts the steps still to finish; a step finishes on each RUN cycle with an empty hold counter.
  property p_steps(local input int n);
    @(posedge clk) disable iff (!rst_n)
      (go, n = int'(len_c)) ##1
      ((state_q == RUN && !bus.abort && !(dly_q == '0 && n == 1), n = n - int'(dly_q == '0)) [*0:$]
       ##1 (state_q == RUN && !bus.abort && dly_q == '0 && n == 1)) |=> bus.done;
  endproperty
  a_done_tail: assert property (p_after_done(!bus.busy ##1 !bus.done));
  a_hold:      assert property (p_while_hold(s_stable(sig_q)));
  a_steps:     assert property (p_steps(0));
`endif
endmodule

// File: tb/tb_seq_stim_gen.sv
// tb_seq_stim_gen: directed scoreboard bench for seq_stim_gen, expectations keyed by cycle number
module tb_seq_stim_gen;
  typedef struct {
    int         cyc;
    logic [1:0] sig;
    logic [2:0] step;
    logic       busy, done, ab, drop;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t;
  exp_t q[$];
  exp_t e;
  seq_stim_gen_if #(.NSIG(2), .DEPTH(8), .DLY_W(4)) bus ();
  seq_stim_gen #(.NSIG(2), .DEPTH(8), .DLY_W(4), .IDLE_VAL(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if ({bus.sig_o, bus.step_o, bus.busy, bus.done, bus.aborted, bus.wr_drop} !==
          {e.sig, e.step, e.busy, e.done, e.ab, e.drop}) begin
        errors++;
        $display("FAIL cyc=%0d sig/step/busy/done/aborted/wr_drop got %b/%0d/%b/%b/%b/%b expected %b/%0d/%b/%b/%b/%b",
                 cyc, bus.sig_o, bus.step_o, bus.busy, bus.done, bus.aborted, bus.wr_drop,
                 e.sig, e.step, e.busy, e.done, e.ab, e.drop);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void ex(int c, logic [1:0] s, logic [2:0] st, logic b, logic d, logic a, logic w);
    exp_t x;
    x.cyc = c; x.sig = s; x.step = st; x.busy = b; x.done = d; x.ab = a; x.drop = w;
    q.push_back(x);
  endfunction
  function automatic void quiet(int c0, int n);
    for (int i = 0; i < n; i++) ex(c0 + i, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic void basic(int c0, logic [1:0] a, logic [1:0] b);
    ex(c0 + 1, a, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) ex(c0 + k, b, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(c0 + 5, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(c0 + 6, 1);
  endfunction
  task automatic wr(int idx, logic [1:0] s, logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_idx = 3'(idx); bus.wr_sig = s; bus.wr_dly = d;
    quiet(cyc + 1, 1);
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic go(int l);
    bus.start = 1'b1; bus.len = 4'(l);
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_sig = '0; bus.wr_dly = '0;
    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
    tick();
    quiet(cyc, 2);
    tick();
    rst_n = 1'b1;
    t = cyc;
    ex(t + 1, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 2, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 3, 1);
    go(1); repeat (2) tick();
    wr(0, 2'b01, 4'd0);
    wr(1, 2'b10, 4'd2);
    t = cyc; basic(t, 2'b01, 2'b10);
    go(2); repeat (5) tick();
    t = cyc;
    ex(t + 1, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 2, 2);
    go(0); repeat (2) tick();
    t = cyc;
    ex(t + 1, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 2, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 3, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(t + 4, 4);
    go(2); tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    repeat (4) tick();
    t = cyc; quiet(t + 1, 3);
    bus.abort = 1'b1; go(2); bus.abort = 1'b0;
    repeat (2) tick();
    t = cyc;
    ex(t + 1, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 2, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 3, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    ex(t + 4, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 5, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 6, 1);
    go(2); tick();
    bus.start = 1'b1; bus.len = 4'd1;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd0; bus.wr_sig = 2'b11; bus.wr_dly = 4'd3;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    repeat (3) tick();
    t = cyc; basic(t, 2'b01, 2'b10);
    go(2); repeat (5) tick();
    t = cyc;
    ex(t + 1, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    ex(t + 2, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 3, 1);
    bus.wr_en = 1'b1; bus.wr_idx = 3'd0; bus.wr_sig = 2'b11; bus.wr_dly = 4'd3;
    go(1);
    bus.wr_en = 1'b0;
    repeat (2) tick();
    t = cyc;
    ex(t + 1, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) ex(t + k, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 2; s <= 7; s++) ex(t + 3 + s, 2'b00, 3'(s), 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 11, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 12, 1);
    go(9); repeat (11) tick();
    t = cyc;
    ex(t + 1, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 2, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(t + 3, 5);
    go(2); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (4) tick();
    t = cyc;
    ex(t + 1, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 2, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(t + 3, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    quiet(t + 4, 1);
    go(2); repeat (3) tick();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
